// File: rtl/fmul_share_arbiter.sv
// Round-robin share of one combinational floatMul among NREQ requesters; registered operand
// stage plus LAT result stages return each product as a one-hot tagged response.
module fmul_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 mul_rst,
  output logic                 mul_en,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_y,
  input  logic                 mul_done,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_y,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned TW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [TW-1:0]  ptr_q, ptr_d;
  logic [TW-1:0]  gnt_idx;
  logic           gnt_any;
  logic [TW-1:0]  idx;

  logic           s0_valid_q;
  logic [TW-1:0]  s0_tag_q;
  logic [31:0]    mul_a_q, mul_b_q;

  logic [LAT-1:0] st_valid_q;
  logic [31:0]    st_y_q   [LAT];
  logic [TW-1:0]  st_tag_q [LAT];

  logic           err_q;

  // Grant the first valid requester at or after the pointer; nothing while stalled or in reset.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    req_ready = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = TW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_any && req_valid[idx] && !stall && rst_n) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Issue stage: operands are held while stalled so the floatMul output stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_tag_q   <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
    end else if (!stall) begin
      s0_valid_q <= gnt_any;
      if (gnt_any) begin
        s0_tag_q <= gnt_idx;
        mul_a_q  <= req_a[{gnt_idx, 5'd0} +: 32];
        mul_b_q  <= req_b[{gnt_idx, 5'd0} +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        st_y_q[i]   <= '0;
        st_tag_q[i] <= '0;
      end
    end else if (!stall) begin
      st_valid_q[0] <= s0_valid_q;
      if (s0_valid_q) begin
        st_y_q[0]   <= mul_y;
        st_tag_q[0] <= s0_tag_q;
      end
      for (int i = 1; i < LAT; i++) begin
        st_valid_q[i] <= st_valid_q[i-1];
        st_y_q[i]     <= st_y_q[i-1];
        st_tag_q[i]   <= st_tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (s0_valid_q && !mul_done) begin
      err_q <= 1'b1;
    end
  end

  // Suppressing the strobe during stall keeps the held result for re-presentation later.
  always_comb begin
    rsp_valid = '0;
    if (st_valid_q[LAT-1] && !stall) rsp_valid = NREQ'(1) << st_tag_q[LAT-1];
  end

  assign rsp_y   = st_y_q[LAT-1];
  assign busy    = s0_valid_q | (|st_valid_q);
  assign err     = err_q;
  assign mul_rst = ~rst_n;
  assign mul_en  = s0_valid_q;
  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;

endmodule
